int_ctrl8: RTL
==============

INT_CTRL8 -- requirements
Module: int_ctrl8

Interface
REQ-001 Parameter ACK_TIMEOUT, default 15: the maximum number of cycles spent in PEND without iAck; the legal range is 1..255.
REQ-002 clk  input  1  is the single clock; all state SHALL update on the rising edge.
REQ-003 rst  input  1  is the reset; it is synchronous and active-high.
REQ-004 iReq  input  8  carries the request lines; they are active-low, and bit 7 has the highest priority.
REQ-005 iMask  input  8  carries the per-line mask; 1 means the line is excluded from arbitration.
REQ-006 iAck  input  1  is the host acknowledge of the currently presented vector.
REQ-007 iEOI  input  1  is the host end-of-service strobe.
REQ-008 oIrq  output  1  is the interrupt request to the host; it is registered.
REQ-009 oVec  output  3  is the binary index of the granted line (7 down to 0); it is registered.
REQ-010 oBusy  output  1  is high while a line is in service; it is registered.
REQ-011 oTmo  output  1  is a one-cycle pulse on acknowledge timeout; it is registered.

Function
REQ-012 The block SHALL hold an 8-bit pending register pend.
- At each edge where iReq[i]==0, pend[i] is set.
- Requests are level-sampled.
- Masked lines still latch into pend.
REQ-013 Eligible set SHALL be pend & ~iMask.
- Winner = highest-index set bit of the eligible set.
- An empty eligible set means there is no winner.
REQ-014 The FSM SHALL have three states, with IDLE as the reset state:
- IDLE
- PEND (interrupt presented, awaiting iAck)
- SERVE (in service, awaiting iEOI)
REQ-015 IDLE -> PEND transition:
- Occurs at an edge where a winner exists.
- Same edge: oVec <= winner, oIrq <= 1.
- With no winner, stay in IDLE, oIrq = 0.
REQ-016 Latency: if iReq[i] is low at edge N, with no competitor and the FSM in IDLE, oIrq SHALL be high after edge N+1 (two cycles).
REQ-017 oVec SHALL hold constant throughout PEND and SERVE.
- A higher-priority arrival or a mask change does not alter oVec until the FSM returns to IDLE.
REQ-018 PEND -> SERVE transition:
- Occurs at an edge with iAck==1.
- Same edge: oIrq <= 0, oBusy <= 1, pend[oVec] <= 0.
REQ-019 If iReq[oVec] is still low at the acknowledging edge, clear SHALL win.
- pend[oVec] re-sets at the next edge only if the line remains low.
REQ-020 PEND SHALL keep an 8-bit wait counter.
- The counter is zeroed on entry to PEND.
- It increments each cycle in PEND without iAck.
REQ-021 When the counter reaches ACK_TIMEOUT-1 and iAck==0, the next edge SHALL perform all of the following:
- Go to IDLE.
- Drive oIrq <= 0 and oTmo <= 1 for exactly one cycle.
- Keep pend[oVec] set.
- Re-arbitration follows from IDLE on the next edge.
REQ-022 If iAck==1 on the same edge the timeout would fire, acknowledge SHALL take precedence: no oTmo, transition to SERVE.
REQ-023 SERVE -> IDLE transition:
- Occurs at an edge with iEOI==1.
- Same edge: oBusy <= 0.
- A new winner is presented no earlier than the following edge.
REQ-024 iAck SHALL be ignored outside PEND, and iEOI SHALL be ignored outside SERVE.
REQ-025 Simultaneous iAck and iEOI SHALL be resolved by the current state only; no state is skipped.
REQ-026 Only one line SHALL be in service at a time; there is no nesting and no preemption.

Reset
REQ-027 When rst==1 at an edge, the following SHALL be true after that edge:
- state = IDLE
- pend = 8'h00
- counter = 0
- oIrq = 0, oVec = 3'b000, oBusy = 0, oTmo = 0
REQ-028 Reset SHALL override every other input, including mid-PEND and mid-SERVE.
- Requests sampled on the reset edge are discarded.

Verification
REQ-029 Single request scenario:
- Stimulus: iReq=8'hFB (line 2) from edge 0, iMask=0.
- Response: oIrq=1, oVec=2 after edge 1.
- Then iAck at edge 3 -> oBusy=1, oIrq=0.
- Then iEOI -> oBusy=0.
REQ-030 Priority scenario:
- Stimulus: iReq=8'h5E (lines 7, 5, 0 low) in one cycle, then all high.
- Response: grants in order 7, 5, 0, each after an ack/EOI cycle.
- pend reaches 0 after the third acknowledge.
REQ-031 Mask scenario:
- Stimulus: iMask=8'h80, iReq=8'h7F pulse.
- Response: no oIrq, and pend=8'h80 is retained.
- Clearing iMask -> oIrq=1, oVec=7 two edges later.
REQ-032 Timeout scenario:
- Stimulus: ACK_TIMEOUT=4, line 3 requested, no iAck.
- Response: after 4 PEND cycles, oTmo pulses once and oIrq drops for one cycle.
- oIrq then rises again with oVec=3.
- A boundary case with iAck on the 4th cycle -> SERVE, no oTmo.
REQ-033 Reset scenario:
- Stimulus: rst asserted for one cycle while in SERVE with pend=8'h12.
- Response: all outputs 0, pend=0, state IDLE; no oIrq until a new request arrives.

Source files
------------

// File: rtl/int_ctrl8.sv
// int_ctrl8: 8-line active-low interrupt controller with fixed priority, ack timeout and single-level service.
module int_ctrl8 #(
    parameter int ACK_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] iReq,
    input  logic [7:0] iMask,
    input  logic       iAck,
    input  logic       iEOI,
    output logic       oIrq,
    output logic [2:0] oVec,
    output logic       oBusy,
    output logic       oTmo
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] PEND  = 2'd1;
    localparam logic [1:0] SERVE = 2'd2;
    localparam logic [7:0] CNT_LAST = 8'(ACK_TIMEOUT - 1);

    logic [1:0] state_q, state_d;
    logic [7:0] pend_q, pend_d;
    logic [7:0] cnt_q, cnt_d;
    logic       irq_q, irq_d;
    logic [2:0] vec_q, vec_d;
    logic       busy_q, busy_d;
    logic       tmo_q, tmo_d;
    logic [7:0] elig;
    logic [2:0] win;
    logic       win_vld;

    always_comb begin
        elig    = pend_q & ~iMask;
        win     = 3'd0;
        win_vld = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (elig[i]) begin
                win     = 3'(i);
                win_vld = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q | ~iReq;
        cnt_d   = cnt_q;
        irq_d   = irq_q;
        vec_d   = vec_q;
        busy_d  = busy_q;
        tmo_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (win_vld) begin
                    state_d = PEND;
                    irq_d   = 1'b1;
                    vec_d   = win;
                    cnt_d   = 8'd0;
                end
            end
            PEND: begin
                // the acknowledge clear beats a still-low request on the same edge
                if (iAck) begin
                    state_d        = SERVE;
                    irq_d          = 1'b0;
                    busy_d         = 1'b1;
                    pend_d[vec_q]  = 1'b0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                    irq_d   = 1'b0;
                    tmo_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            SERVE: begin
                if (iEOI) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pend_q  <= 8'h00;
            cnt_q   <= 8'd0;
            irq_q   <= 1'b0;
            vec_q   <= 3'd0;
            busy_q  <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            cnt_q   <= cnt_d;
            irq_q   <= irq_d;
            vec_q   <= vec_d;
            busy_q  <= busy_d;
            tmo_q   <= tmo_d;
        end
    end

    assign oIrq  = irq_q;
    assign oVec  = vec_q;
    assign oBusy = busy_q;
    assign oTmo  = tmo_q;
endmodule
